// File: rtl/axi_stream_frame_gen_pkg.sv
// ============================================================================
// Module  : axi_stream_frame_gen_pkg
// Brief   : Shared types and constants for the AXI4-Stream RGB frame generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_stream_frame_gen_pkg;

    localparam int PIX_W = 24;

    localparam logic [PIX_W-1:0] c_pix_white = 24'hFF_FF_FF;
    localparam logic [PIX_W-1:0] c_pix_black = 24'h00_00_00;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_HRAMP = 2'd1,
        PAT_VRAMP = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/axi_stream_frame_gen_pattern.sv
// ============================================================================
// Module  : frame_gen_pattern
// Brief   : Combinational pixel function: (pattern, x, y, colour) -> RGB pixel.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_gen_pattern
    import axi_stream_frame_gen_pkg::*;
#(
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int CHK_LOG2 = 3
) (
    input  pattern_e         i_pattern,
    input  logic [XW-1:0]    i_x,
    input  logic [YW-1:0]    i_y,
    input  logic [PIX_W-1:0] i_color,
    output logic [PIX_W-1:0] o_pixel
);

    logic [7:0] w_x8;
    logic [7:0] w_y8;
    logic       w_x_chk;
    logic       w_y_chk;

    // Size casts give the modulo-256 ramp and zero-extend narrow counters.
    assign w_x8    = 8'(i_x);
    assign w_y8    = 8'(i_y);
    assign w_x_chk = 1'(i_x >> CHK_LOG2);
    assign w_y_chk = 1'(i_y >> CHK_LOG2);

    always_comb begin
        o_pixel = c_pix_black;
        case (i_pattern)
            PAT_SOLID: o_pixel = i_color;
            PAT_HRAMP: o_pixel = {w_x8, w_x8, w_x8};
            PAT_VRAMP: o_pixel = {w_y8, w_y8, w_y8};
            PAT_CHECK: o_pixel = (w_x_chk ^ w_y_chk) ? c_pix_white : c_pix_black;
            default:   o_pixel = c_pix_black;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/axi_stream_frame_gen.sv
// ============================================================================
// Module  : axi_stream_frame_gen
// Brief   : AXI4-Stream master emitting test frames of 24-bit RGB pixels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_stream_frame_gen
    import axi_stream_frame_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CHK_LOG2   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       pattern_sel_i,
    input  logic [PIX_W-1:0] color_i,
    input  logic [7:0]       num_frames_i,
    input  logic             stop_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             tvalid_o,
    input  logic             tready_i,
    output logic             tlast_o,
    output logic [PIX_W-1:0] tdata_o
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [XW-1:0] c_x_last = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] c_y_last = YW'(IMG_HEIGHT - 1);

    state_e           r_state;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [7:0]       r_frame_cnt;
    logic             r_stop;
    pattern_e         r_pattern;
    logic [PIX_W-1:0] r_color;
    logic [7:0]       r_num_frames;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_tvalid;
    logic             r_tlast;
    logic [PIX_W-1:0] r_tdata;

    logic             w_hs;
    logic             w_x_wrap;
    logic             w_y_wrap;
    logic [XW-1:0]    w_x_next;
    logic [YW-1:0]    w_y_next;
    logic [7:0]       w_cnt_next;
    logic             w_run_over;
    pattern_e         w_pat_pattern;
    logic [PIX_W-1:0] w_pat_color;
    logic [XW-1:0]    w_pat_x;
    logic [YW-1:0]    w_pat_y;
    logic [PIX_W-1:0] w_pixel;

    assign w_hs       = r_tvalid & tready_i;
    assign w_x_wrap   = (r_x == c_x_last);
    assign w_y_wrap   = (r_y == c_y_last);
    assign w_x_next   = w_x_wrap ? '0 : r_x + 1'b1;
    assign w_y_next   = w_x_wrap ? (w_y_wrap ? '0 : r_y + 1'b1) : r_y;
    assign w_cnt_next = r_frame_cnt + 8'd1;
    assign w_run_over = r_stop | stop_i |
                        ((r_num_frames != 8'd0) && (w_cnt_next == r_num_frames));

    // The output register always holds the presented pixel, so the pattern is
    // evaluated one pixel ahead: pixel (0,0) from live inputs at start, else the
    // successor of the current coordinates using the latched configuration.
    assign w_pat_pattern = (r_state == ST_IDLE) ? pattern_e'(pattern_sel_i) : r_pattern;
    assign w_pat_color   = (r_state == ST_IDLE) ? color_i : r_color;
    assign w_pat_x       = (r_state == ST_IDLE) ? '0 : w_x_next;
    assign w_pat_y       = (r_state == ST_IDLE) ? '0 : w_y_next;

    frame_gen_pattern #(
        .XW       (XW),
        .YW       (YW),
        .CHK_LOG2 (CHK_LOG2)
    ) u_pattern (
        .i_pattern (w_pat_pattern),
        .i_x       (w_pat_x),
        .i_y       (w_pat_y),
        .i_color   (w_pat_color),
        .o_pixel   (w_pixel)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_cnt  <= 8'd0;
            r_stop       <= 1'b0;
            r_pattern    <= PAT_SOLID;
            r_color      <= '0;
            r_num_frames <= 8'd0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tdata      <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b1;
                        r_pattern    <= pattern_e'(pattern_sel_i);
                        r_color      <= color_i;
                        r_num_frames <= num_frames_i;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_frame_cnt  <= 8'd0;
                        r_stop       <= 1'b0;
                        r_tvalid     <= 1'b1;
                        r_tlast      <= 1'b0;
                        r_tdata      <= w_pixel;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        r_stop <= 1'b1;
                    end
                    if (w_hs) begin
                        r_x     <= w_x_next;
                        r_y     <= w_y_next;
                        r_tdata <= w_pixel;
                        r_tlast <= (w_x_next == c_x_last);
                        if (w_x_wrap && w_y_wrap) begin
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= w_cnt_next;
                            if (w_run_over) begin
                                r_state  <= ST_IDLE;
                                r_busy   <= 1'b0;
                                r_stop   <= 1'b0;
                                r_tvalid <= 1'b0;
                                r_tlast  <= 1'b0;
                                r_tdata  <= '0;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;
    assign tvalid_o     = r_tvalid;
    assign tlast_o      = r_tlast;
    assign tdata_o      = r_tdata;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_frame_gen.sv
// ============================================================================
// Module  : tb_axi_stream_frame_gen
// Brief   : Directed self-checking bench for axi_stream_frame_gen (4x3 and 2x300).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_stream_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, tready;
    logic [1:0]  psel;
    logic [23:0] color;
    logic [7:0]  nframes;
    logic        busy, fdone, tvalid, tlast;
    logic [23:0] tdata;

    logic        t_start, t_busy, t_fdone, t_tvalid, t_tlast;
    logic        t_stop   = 1'b0;
    logic        t_tready = 1'b1;
    logic [1:0]  t_psel   = 2'd2;
    logic [7:0]  t_nfr    = 8'd1;
    logic [23:0] t_tdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fd_count = 0;
    logic [24:0] q_beat[$];
    int          q_cyc[$];
    logic [24:0] q_tall[$];

    logic [23:0] hexp [4]  = '{24'h000000, 24'h010101, 24'h020202, 24'h030303};
    logic [23:0] cexp [12] = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                               24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                               24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};

    always #5 clk = ~clk;

    axi_stream_frame_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .CHK_LOG2(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pattern_sel_i(psel),
        .color_i(color), .num_frames_i(nframes), .stop_i(stop), .busy_o(busy),
        .frame_done_o(fdone), .tvalid_o(tvalid), .tready_i(tready),
        .tlast_o(tlast), .tdata_o(tdata)
    );

    axi_stream_frame_gen #(.IMG_WIDTH(2), .IMG_HEIGHT(300), .CHK_LOG2(1)) u_tall (
        .clk_i(clk), .rst_i(rst), .start_i(t_start), .pattern_sel_i(t_psel),
        .color_i(color), .num_frames_i(t_nfr), .stop_i(t_stop), .busy_o(t_busy),
        .frame_done_o(t_fdone), .tvalid_o(t_tvalid), .tready_i(t_tready),
        .tlast_o(t_tlast), .tdata_o(t_tdata)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst) begin
            if (tvalid && tready) begin
                q_beat.push_back({tlast, tdata});
                q_cyc.push_back(cyc);
            end
            if (fdone) fd_count++;
            if (t_tvalid && t_tready) q_tall.push_back({t_tlast, t_tdata});
        end
    end

    // Protocol monitor: a stalled beat must still be valid with the same payload.
    logic        p_stall = 1'b0;
    logic [24:0] p_pay   = '0;
    always @(posedge clk) begin
        if (rst) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                checks++;
                if (tvalid !== 1'b1 || {tlast, tdata} !== p_pay) begin
                    errors++;
                    $display("FAIL protocol_stall: valid=%b payload=%h, required valid=1 payload=%h",
                             tvalid, {tlast, tdata}, p_pay);
                end
            end
            p_stall = tvalid && !tready;
            p_pay   = {tlast, tdata};
        end
    end

    task automatic clear_log();
        q_beat.delete();
        q_cyc.delete();
        fd_count = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = !busy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, fdone, tvalid, tlast, tdata} !== 28'd0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h, required 0", {busy, fdone, tvalid, tlast, tdata});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, fdone, tvalid, tlast, tdata} !== 28'd0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h, required 0", {busy, fdone, tvalid, tlast, tdata});
        end
    endtask

    task automatic test_hramp();
        psel = 2'd1; nframes = 8'd1; tready = 1'b1;
        clear_log();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (tvalid !== 1'b1 || tdata !== hexp[i % 4]) begin
                errors++;
                $display("FAIL hramp_data[%0d]: valid=%b data=%h, required 1 %h", i, tvalid, tdata, hexp[i % 4]);
            end
            checks++;
            if (tlast !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL hramp_last[%0d]: got %b, required %b", i, tlast, (i % 4 == 3));
            end
            @(negedge clk);
        end
        checks++;
        if (fdone !== 1'b1 || busy !== 1'b0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL hramp_end: fdone=%b busy=%b valid=%b, required 1 0 0", fdone, busy, tvalid);
        end
        @(negedge clk);
        checks++;
        if (fdone !== 1'b0 || fd_count !== 1) begin
            errors++;
            $display("FAIL hramp_done_pulse: fdone=%b count=%0d, required 0 1", fdone, fd_count);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        psel = 2'd1; nframes = 8'd1;
        clear_log();
        @(negedge clk) begin start = 1'b1; tready = 1'($urandom_range(0, 1)); end
        @(negedge clk) start = 1'b0;
        while (busy && n < 300) begin
            tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        tready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q_beat.size() != 12 || fd_count != 1) begin
            errors++;
            $display("FAIL bp_count: busy=%b beats=%0d done=%0d, required 0 12 1", busy, q_beat.size(), fd_count);
        end
        for (int i = 0; i < q_beat.size() && i < 12; i++) begin
            checks++;
            if (q_beat[i] !== {1'(i % 4 == 3), hexp[i % 4]}) begin
                errors++;
                $display("FAIL bp_beat[%0d]: got %h, required %h", i, q_beat[i], {1'(i % 4 == 3), hexp[i % 4]});
            end
        end
    endtask

    task automatic test_checker_stop();
        bit ok;
        psel = 2'd3; nframes = 8'd0; tready = 1'b1;
        clear_log();
        pulse_start();
        repeat (30) @(negedge clk);
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok || q_beat.size() != 36 || fd_count != 3) begin
            errors++;
            $display("FAIL chk_stop_count: idle=%b beats=%0d done=%0d, required 1 36 3", ok, q_beat.size(), fd_count);
        end
        for (int i = 0; i < q_beat.size() && i < 36; i++) begin
            checks++;
            if (q_beat[i] !== {1'(i % 4 == 3), cexp[i % 12]}) begin
                errors++;
                $display("FAIL chk_beat[%0d]: got %h, required %h", i, q_beat[i], {1'(i % 4 == 3), cexp[i % 12]});
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tvalid !== 1'b0 || fd_count != 3) begin
            errors++;
            $display("FAIL chk_stays_idle: busy=%b valid=%b done=%0d, required 0 0 3", busy, tvalid, fd_count);
        end
    endtask

    task automatic test_solid();
        bit ok;
        psel = 2'd0; nframes = 8'd2; color = 24'h123456;
        clear_log();
        pulse_start();
        repeat (5) @(negedge clk);
        color = 24'hABCDEF;
        wait_idle(100, ok);
        checks++;
        if (!ok || q_beat.size() != 24 || fd_count != 2) begin
            errors++;
            $display("FAIL solid_count: idle=%b beats=%0d done=%0d, required 1 24 2", ok, q_beat.size(), fd_count);
        end
        for (int i = 0; i < q_beat.size() && i < 24; i++) begin
            checks++;
            if (q_beat[i][23:0] !== 24'h123456) begin
                errors++;
                $display("FAIL solid_beat[%0d]: got %h, required 123456", i, q_beat[i][23:0]);
            end
        end
        if (q_cyc.size() == 24) begin
            checks++;
            if (q_cyc[23] - q_cyc[0] != 23) begin
                errors++;
                $display("FAIL solid_back_to_back: span=%0d cycles, required 23", q_cyc[23] - q_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        psel = 2'd1; nframes = 8'd1; tready = 1'b1;
        clear_log();
        pulse_start();
        repeat (5) @(negedge clk);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 24'h010101) begin
            errors++;
            $display("FAIL rstmid_pre: valid=%b data=%h, required 1 010101", tvalid, tdata);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, fdone, tvalid, tlast, tdata} !== 28'd0) begin
            errors++;
            $display("FAIL rstmid_async: outputs=%h, required 0", {busy, fdone, tvalid, tlast, tdata});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, fdone, tvalid, tlast, tdata} !== 28'd0) begin
            errors++;
            $display("FAIL rstmid_held: outputs=%h, required 0", {busy, fdone, tvalid, tlast, tdata});
        end
        rst = 1'b0;
        clear_log();
        pulse_start();
        checks++;
        if (tvalid !== 1'b1 || tlast !== 1'b0 || tdata !== 24'h000000) begin
            errors++;
            $display("FAIL rstmid_restart: valid=%b last=%b data=%h, required 1 0 000000", tvalid, tlast, tdata);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok || q_beat.size() != 12 || fd_count != 1) begin
            errors++;
            $display("FAIL rstmid_rerun: idle=%b beats=%0d done=%0d, required 1 12 1", ok, q_beat.size(), fd_count);
        end
    endtask

    task automatic test_start_ignore();
        bit ok;
        psel = 2'd0; nframes = 8'd1; color = 24'h00FF00;
        clear_log();
        pulse_start();
        repeat (4) @(negedge clk);
        psel = 2'd1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idle(100, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b0 || q_beat.size() != 12 || fd_count != 1) begin
            errors++;
            $display("FAIL run_start_ignored: busy=%b beats=%0d done=%0d, required 0 12 1", busy, q_beat.size(), fd_count);
        end
        if (q_beat.size() == 12) begin
            checks++;
            if (q_beat[11] !== {1'b1, 24'h00FF00}) begin
                errors++;
                $display("FAIL run_start_cfg: last beat %h, required 100ff00", q_beat[11]);
            end
        end
        clear_log();
        @(negedge clk) begin start = 1'b1; stop = 1'b1; end
        @(negedge clk) begin start = 1'b0; stop = 1'b0; end
        wait_idle(100, ok);
        checks++;
        if (!ok || q_beat.size() != 12 || fd_count != 1) begin
            errors++;
            $display("FAIL start_stop_idle: idle=%b beats=%0d done=%0d, required 1 12 1", ok, q_beat.size(), fd_count);
        end
        if (q_beat.size() == 12) begin
            checks++;
            if (q_beat[11] !== {1'b1, 24'h030303}) begin
                errors++;
                $display("FAIL start_stop_last: got %h, required 1030303", q_beat[11]);
            end
        end
    endtask

    task automatic test_vramp_tall();
        int n = 0;
        q_tall.delete();
        @(negedge clk) t_start = 1'b1;
        @(negedge clk) t_start = 1'b0;
        while (t_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (t_busy !== 1'b0 || q_tall.size() != 600) begin
            errors++;
            $display("FAIL tall_count: busy=%b beats=%0d, required 0 600", t_busy, q_tall.size());
        end
        if (q_tall.size() == 600) begin
            checks++;
            if (q_tall[510] !== {1'b0, 24'hFFFFFF}) begin
                errors++;
                $display("FAIL tall_line255: got %h, required 0ffffff", q_tall[510]);
            end
            checks++;
            if (q_tall[512] !== {1'b0, 24'h000000} || q_tall[513] !== {1'b1, 24'h000000}) begin
                errors++;
                $display("FAIL tall_line256: got %h %h, required 0000000 1000000", q_tall[512], q_tall[513]);
            end
            checks++;
            if (q_tall[514] !== {1'b0, 24'h010101}) begin
                errors++;
                $display("FAIL tall_line257: got %h, required 0010101", q_tall[514]);
            end
            checks++;
            if (q_tall[599] !== {1'b1, 24'h2B2B2B}) begin
                errors++;
                $display("FAIL tall_line299: got %h, required 12b2b2b", q_tall[599]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b1; t_start = 1'b0;
        psel = 2'd0; color = 24'd0; nframes = 8'd1;
        test_reset();
        test_hramp();
        test_backpressure();
        test_checker_stop();
        test_solid();
        test_reset_midframe();
        test_start_ignore();
        test_vramp_tall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
